// File: rtl/univ_shift_reg_pkg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg_pkg
// Shared definitions for the universal shift register slice.
//   - Mode encodings driven on the mode bus.
//   - cnt_width(): width of the shift counter able to hold 0..w inclusive.
// ---------------------------------------------------------------------------
package univ_shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // The counter saturates at w itself, so it needs room for w+1 values.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// ---------------------------------------------------------------------------
// univ_shift_reg_if
// Bundles the control/data signals of the universal shift register.
//   ena       clock enable for all register state
//   mode      00 hold, 01 shift right, 10 shift left, 11 parallel load
//   d         parallel load data (WIDTH bits)
//   sin       serial input bit (ignored by rotating instances)
//   q         registered contents (WIDTH bits)
//   sout_msb  q[WIDTH-1], serial out when shifting left
//   sout_lsb  q[0], serial out when shifting right
//   cnt       shifts since last load, saturating at WIDTH
//   done      one-cycle pulse on the WIDTH-th shift
// master: the side driving ena/mode/d/sin. slave: the shift register.
// ---------------------------------------------------------------------------
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);
    import univ_shift_reg_pkg::*;

    localparam int CNT_W = cnt_width(WIDTH);

    logic             ena;
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout_msb;
    logic             sout_lsb;
    logic [CNT_W-1:0] cnt;
    logic             done;

    modport master (
        output ena, mode, d, sin,
        input  q, sout_msb, sout_lsb, cnt, done
    );

    modport slave (
        input  ena, mode, d, sin,
        output q, sout_msb, sout_lsb, cnt, done
    );

endinterface

// File: rtl/univ_shift_reg_bit_cell.sv
// ---------------------------------------------------------------------------
// univ_shift_reg_bit_cell
// One storage bit of the universal shift register: a 4:1 next-state mux
// (hold / shift-right source / shift-left source / load data) feeding a
// D flip-flop with synchronous reset and clock enable.
//   clk, rst  clock and synchronous active-high reset
//   ena       enable; 0 holds the bit
//   mode      operation select shared by all cells
//   shr_in    value taken on a right shift (upper neighbour or fill)
//   shl_in    value taken on a left shift (lower neighbour or fill)
//   load_in   value taken on a parallel load
//   rst_bit   value taken on reset
//   q         stored bit
// ---------------------------------------------------------------------------
module univ_shift_reg_bit_cell
    import univ_shift_reg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [1:0] mode,
    input  logic       shr_in,
    input  logic       shl_in,
    input  logic       load_in,
    input  logic       rst_bit,
    output logic       q
);

    logic q_q;
    logic q_d;

    // Select the next value of this bit; anything other than an enabled
    // shift or load keeps the current value.
    always_comb begin
        q_d = q_q;
        if (ena) begin
            unique case (mode)
                MODE_SHR:  q_d = shr_in;
                MODE_SHL:  q_d = shl_in;
                MODE_LOAD: q_d = load_in;
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= rst_bit;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
// Parametrised universal shift register: hold, shift right, shift left and
// parallel load, optional end-around rotate, plus a shift counter that
// pulses done on the WIDTH-th shift after a load.
// Parameters:
//   WIDTH    register width, 2..32
//   ROTATE   1: shifts circulate and sin is ignored; 0: sin fills
//   RST_VAL  value of q after reset (must fit in WIDTH bits)
// Ports:
//   clk  single clock, all state on posedge
//   rst  synchronous active-high reset, priority over everything
//   bus  univ_shift_reg_if slave modport (ena/mode/d/sin in, q/sout/cnt/done out)
// ---------------------------------------------------------------------------
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int          WIDTH   = 8,
    parameter int          ROTATE  = 0,
    parameter logic [31:0] RST_VAL = 32'h0
) (
    input  logic          clk,
    input  logic          rst,
    univ_shift_reg_if.slave bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("univ_shift_reg: WIDTH must be in 2..32");
    end

    if ((RST_VAL >> WIDTH) != 32'd0) begin : g_bad_rst_val
        $error("univ_shift_reg: RST_VAL does not fit in WIDTH bits");
    end

    logic [WIDTH-1:0] q_vec;
    logic [WIDTH-1:0] shr_vec;
    logic [WIDTH-1:0] shl_vec;
    logic             fill_r;
    logic             fill_l;

    // With rotate enabled the bit falling off one end re-enters at the other.
    assign fill_r  = (ROTATE != 0) ? q_vec[0]       : bus.sin;
    assign fill_l  = (ROTATE != 0) ? q_vec[WIDTH-1] : bus.sin;
    assign shr_vec = {fill_r, q_vec[WIDTH-1:1]};
    assign shl_vec = {q_vec[WIDTH-2:0], fill_l};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        univ_shift_reg_bit_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .ena     (bus.ena),
            .mode    (bus.mode),
            .shr_in  (shr_vec[i]),
            .shl_in  (shl_vec[i]),
            .load_in (bus.d[i]),
            .rst_bit (RST_VAL[i]),
            .q       (q_vec[i])
        );
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             done_q;
    logic             done_d;

    // Count shifts in either direction since the last load. The count stops
    // at WIDTH, and done fires only on the step that reaches it.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (bus.ena) begin
            unique case (bus.mode)
                MODE_SHR, MODE_SHL: begin
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        cnt_d  = CNT_W'(WIDTH);
                        done_d = 1'b1;
                    end else if (cnt_q < CNT_W'(WIDTH - 1)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                MODE_LOAD: cnt_d = '0;
                default:   cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bus.q        = q_vec;
    assign bus.sout_msb = q_vec[WIDTH-1];
    assign bus.sout_lsb = q_vec[0];
    assign bus.cnt      = cnt_q;
    assign bus.done     = done_q;

endmodule
